// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEXEC,
        S_ADDIWB,
        S_JUMP
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps the FSM's ALU intent plus the R-type funct field to an ALU operation.
// Purely combinational; unknown functs fall back to add and are flagged.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_control,
    output logic        funct_illegal
);

    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        case (aluop)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: funct_illegal = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute over the shared datapath.
// Moore outputs except pc_en (uses zero) and alu_control (uses funct); write enables held low in reset.
module mips_mc_control
    import mips_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pc_en,
    output logic        iord,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_src,
    output logic [2:0]  alu_control,
    output logic        illegal
);

    state_t r_state;
    state_t w_next;
    aluop_t w_aluop;
    logic   r_illegal;
    logic   w_pc_write;
    logic   w_branch;
    logic   w_mem_write;
    logic   w_ir_write;
    logic   w_reg_write;
    logic   w_op_illegal;
    logic   w_funct_illegal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= RESET_STATE;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_op_illegal || (r_state == S_EXECUTE && w_funct_illegal))
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next       = S_FETCH;
        w_aluop      = ALUOP_ADD;
        w_op_illegal = 1'b0;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        iord         = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        pc_src       = 2'b00;
        case (r_state)
            S_FETCH: begin
                alu_src_b  = 2'b01;
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEXEC;
                    OP_J:         w_next = S_JUMP;
                    default:      w_op_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord   = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg  = 1'b1;
                w_reg_write = 1'b1;
            end
            S_MEMWR: begin
                iord        = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                w_aluop   = ALUOP_FUNCT;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst     = 1'b1;
                w_reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                w_aluop   = ALUOP_SUB;
                pc_src    = 2'b01;
                w_branch  = 1'b1;
            end
            S_ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: w_reg_write = 1'b1;
            S_JUMP: begin
                pc_src     = 2'b10;
                w_pc_write = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    mips_alu_decoder u_alu_dec (
        .aluop         (w_aluop),
        .funct         (funct),
        .alu_control   (alu_control),
        .funct_illegal (w_funct_illegal)
    );

    // Gate on branch first so an unknown zero outside BRANCH cannot leak into pc_en.
    assign pc_en     = rst & (w_pc_write | (w_branch ? zero : 1'b0));
    assign mem_write = rst & w_mem_write;
    assign ir_write  = rst & w_ir_write;
    assign reg_write = rst & w_reg_write;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: walks each instruction class and checks per-cycle control words.
module tb_mips_mc_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       illegal;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mips_mc_control dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .alu_control(alu_control), .illegal(illegal)
    );

    // {pc_en,iord,mem_write,ir_write,reg_write,reg_dst,mem_to_reg,alu_src_a,alu_src_b,pc_src,alu_control}
    logic [14:0] sig;
    assign sig = {pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                  alu_src_a, alu_src_b, pc_src, alu_control};

    localparam logic [14:0] SIG_RESET   = 15'b0_0_0_0_0_0_0_0_01_00_010;
    localparam logic [14:0] SIG_FETCH   = 15'b1_0_0_1_0_0_0_0_01_00_010;
    localparam logic [14:0] SIG_DECODE  = 15'b0_0_0_0_0_0_0_0_11_00_010;
    localparam logic [14:0] SIG_MEMADR  = 15'b0_0_0_0_0_0_0_1_10_00_010;
    localparam logic [14:0] SIG_MEMRD   = 15'b0_1_0_0_0_0_0_0_00_00_010;
    localparam logic [14:0] SIG_MEMWB   = 15'b0_0_0_0_1_0_1_0_00_00_010;
    localparam logic [14:0] SIG_MEMWR   = 15'b0_1_1_0_0_0_0_0_00_00_010;
    localparam logic [14:0] SIG_EX_SLT  = 15'b0_0_0_0_0_0_0_1_00_00_111;
    localparam logic [14:0] SIG_EX_ADD  = 15'b0_0_0_0_0_0_0_1_00_00_010;
    localparam logic [14:0] SIG_ALUWB   = 15'b0_0_0_0_1_1_0_0_00_00_010;
    localparam logic [14:0] SIG_BR_T    = 15'b1_0_0_0_0_0_0_1_00_01_110;
    localparam logic [14:0] SIG_BR_NT   = 15'b0_0_0_0_0_0_0_1_00_01_110;
    localparam logic [14:0] SIG_ADDIEX  = 15'b0_0_0_0_0_0_0_1_10_00_010;
    localparam logic [14:0] SIG_ADDIWB  = 15'b0_0_0_0_1_0_0_0_00_00_010;
    localparam logic [14:0] SIG_JUMP    = 15'b1_0_0_0_0_0_0_0_00_10_010;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Checks the control word for the current state, then advances one clock.
    task automatic cyc(input string tag, input logic [14:0] exp);
        #1;
        check(tag, {17'd0, sig}, {17'd0, exp});
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; op = 6'b000000; funct = 6'b000000; zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_word", {17'd0, sig}, {17'd0, SIG_RESET});
        check("reset_illegal", {31'd0, illegal}, 32'd0);

        // lw: 5 states, back in FETCH on cycle 6
        op = 6'b100011; zero = 1'bx;
        rst = 1'b1;
        cyc("lw_fetch", SIG_FETCH);
        cyc("lw_decode", SIG_DECODE);
        cyc("lw_memadr", SIG_MEMADR);
        cyc("lw_memrd", SIG_MEMRD);
        cyc("lw_memwb", SIG_MEMWB);

        // R-type slt
        op = 6'b000000; funct = 6'b101010;
        cyc("slt_fetch", SIG_FETCH);
        cyc("slt_decode", SIG_DECODE);
        cyc("slt_execute", SIG_EX_SLT);
        cyc("slt_aluwb", SIG_ALUWB);
        check("slt_illegal", {31'd0, illegal}, 32'd0);

        // beq taken then not taken
        op = 6'b000100; funct = 6'b111111;
        cyc("beq_t_fetch", SIG_FETCH);
        cyc("beq_t_decode", SIG_DECODE);
        zero = 1'b1;
        cyc("beq_t_branch", SIG_BR_T);
        zero = 1'bx;
        cyc("beq_nt_fetch", SIG_FETCH);
        cyc("beq_nt_decode", SIG_DECODE);
        zero = 1'b0;
        cyc("beq_nt_branch", SIG_BR_NT);
        zero = 1'bx;
        check("beq_illegal", {31'd0, illegal}, 32'd0);

        // j
        op = 6'b000010;
        cyc("j_fetch", SIG_FETCH);
        cyc("j_decode", SIG_DECODE);
        cyc("j_jump", SIG_JUMP);

        // illegal opcode: FETCH, DECODE, then back to FETCH
        op = 6'b111111;
        cyc("ill_fetch", SIG_FETCH);
        #1 check("ill_before", {31'd0, illegal}, 32'd0);
        cyc("ill_decode", SIG_DECODE);

        // addi after illegal op, flag stays set
        op = 6'b001000;
        check("ill_set", {31'd0, illegal}, 32'd1);
        cyc("addi_fetch", SIG_FETCH);
        cyc("addi_decode", SIG_DECODE);
        cyc("addi_exec", SIG_ADDIEX);
        cyc("addi_wb", SIG_ADDIWB);
        check("ill_sticky", {31'd0, illegal}, 32'd1);

        // sw with reset asserted during MEMWR
        op = 6'b101011;
        cyc("sw_fetch", SIG_FETCH);
        cyc("sw_decode", SIG_DECODE);
        cyc("sw_memadr", SIG_MEMADR);
        #1 check("sw_memwr", {17'd0, sig}, {17'd0, SIG_MEMWR});
        #1 rst = 1'b0;
        #1 check("sw_rst_memwrite", {31'd0, mem_write}, 32'd0);
        check("sw_rst_word", {17'd0, sig}, {17'd0, SIG_RESET});
        check("sw_rst_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // R-type with unsupported funct: add fallback, flag set on EXECUTE edge, ALUWB still writes
        op = 6'b000000; funct = 6'b000111;
        cyc("badfn_fetch", SIG_FETCH);
        cyc("badfn_decode", SIG_DECODE);
        #1 check("badfn_pre", {31'd0, illegal}, 32'd0);
        cyc("badfn_execute", SIG_EX_ADD);
        cyc("badfn_aluwb", SIG_ALUWB);
        check("badfn_illegal", {31'd0, illegal}, 32'd1);
        cyc("final_fetch", SIG_FETCH);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
